// File: rtl/relobi_arbiter.sv
// relobi_arbiter: round-robin arbiter sharing one reliable-OBI subordinate among NumMgr managers,
// with TMR-voted handshakes, triplicated self-correcting control state and fault reporting.
package relobi_arbiter_pkg;
  typedef struct packed {
    logic UseRReady;
  } cfg_t;
  localparam cfg_t ObiDefaultConfig = '{UseRReady: 1'b0};
  typedef struct packed {
    logic [2:0]  req;
    logic [2:0]  rready;
    logic [31:0] a;
  } relobi_req_t;
  typedef struct packed {
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] r;
  } relobi_rsp_t;
endpackage

module relobi_arbiter #(
  parameter relobi_arbiter_pkg::cfg_t Cfg = relobi_arbiter_pkg::ObiDefaultConfig,
  parameter int unsigned NumMgr = 2,
  parameter int unsigned MaxTrans = 4,
  parameter type relobi_req_t = relobi_arbiter_pkg::relobi_req_t,
  parameter type relobi_rsp_t = relobi_arbiter_pkg::relobi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  relobi_req_t sbr_ports_req_i [NumMgr],
  output relobi_rsp_t sbr_ports_rsp_o [NumMgr],
  output relobi_req_t mgr_port_req_o,
  input  relobi_rsp_t mgr_port_rsp_i,
  output logic [1:0]  fault_o
);
  localparam int unsigned IW = NumMgr > 1 ? $clog2(NumMgr) : 1;
  localparam int unsigned CW = $clog2(MaxTrans + 1);
  localparam int unsigned PW = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
  function automatic logic maj3(input logic [2:0] t);
    return (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
  endfunction
  function automatic logic bad3(input logic [2:0] t);
    return |t & ~&t;
  endfunction
  logic [2:0][IW-1:0] rr_q, lidx_q;
  logic [2:0]         lock_q;
  logic [2:0][CW-1:0] cnt_q;
  logic [2:0][PW-1:0] wp_q, rp_q;
  logic [2:0][IW-1:0] fifo_q [MaxTrans];
  logic [IW-1:0] rr, lidx, head, sel, cand, rr_d, lidx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [PW-1:0] wp, rp, wp_d, rp_d;
  logic [NumMgr-1:0] req_v, rready_v;
  logic lock, lock_d, lk, sel_v, full, has, push, pop, gnt_v, rvalid_v, rready_out, in_bad, st_bad;
  always_comb begin
    rr = (rr_q[0] & rr_q[1]) | (rr_q[0] & rr_q[2]) | (rr_q[1] & rr_q[2]);
    lidx = (lidx_q[0] & lidx_q[1]) | (lidx_q[0] & lidx_q[2]) | (lidx_q[1] & lidx_q[2]);
    cnt = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
    wp = (wp_q[0] & wp_q[1]) | (wp_q[0] & wp_q[2]) | (wp_q[1] & wp_q[2]);
    rp = (rp_q[0] & rp_q[1]) | (rp_q[0] & rp_q[2]) | (rp_q[1] & rp_q[2]);
    head = (fifo_q[rp][0] & fifo_q[rp][1]) | (fifo_q[rp][0] & fifo_q[rp][2]) | (fifo_q[rp][1] & fifo_q[rp][2]);
    lock = maj3(lock_q);
    has = cnt != '0;
    full = cnt == CW'(MaxTrans);
    st_bad = rr_q[0] != rr_q[1] || rr_q[1] != rr_q[2] || lidx_q[0] != lidx_q[1] || lidx_q[1] != lidx_q[2]
          || bad3(lock_q) || cnt_q[0] != cnt_q[1] || cnt_q[1] != cnt_q[2]
          || wp_q[0] != wp_q[1] || wp_q[1] != wp_q[2] || rp_q[0] != rp_q[1] || rp_q[1] != rp_q[2]
          || (has && (fifo_q[rp][0] != fifo_q[rp][1] || fifo_q[rp][1] != fifo_q[rp][2]));
    gnt_v = maj3(mgr_port_rsp_i.gnt);
    rvalid_v = maj3(mgr_port_rsp_i.rvalid);
    in_bad = bad3(mgr_port_rsp_i.gnt) | bad3(mgr_port_rsp_i.rvalid);
    for (int i = 0; i < int'(NumMgr); i++) begin
      req_v[i] = maj3(sbr_ports_req_i[i].req);
      rready_v[i] = maj3(sbr_ports_req_i[i].rready);
      in_bad = in_bad | bad3(sbr_ports_req_i[i].req) | bad3(sbr_ports_req_i[i].rready);
    end
    // a lock only pins the selection while its owner keeps requesting
    lk = lock && req_v[lidx];
    sel = lidx;
    sel_v = lk;
    cand = '0;
    for (int k = int'(NumMgr) - 1; k >= 0; k--) begin
      cand = IW'((int'(rr) + k) % int'(NumMgr));
      if (!lk && req_v[cand]) begin
        sel = cand;
        sel_v = 1'b1;
      end
    end
    push = !rst_i && !full && sel_v && gnt_v;
    rready_out = !has || !Cfg.UseRReady || rready_v[head];
    pop = has && rvalid_v && rready_out;
    mgr_port_req_o = sbr_ports_req_i[sel];
    mgr_port_req_o.req = {3{!rst_i && !full && sel_v}};
    mgr_port_req_o.rready = {3{rready_out}};
    cnt_d = cnt + CW'(push) - CW'(pop);
    wp_d = push ? (wp == PW'(MaxTrans - 1) ? '0 : wp + 1'b1) : wp;
    rp_d = pop ? (rp == PW'(MaxTrans - 1) ? '0 : rp + 1'b1) : rp;
    lock_d = full ? lock : sel_v && !gnt_v;
    lidx_d = (!full && sel_v && !gnt_v) ? sel : lidx;
    rr_d = push ? (sel == IW'(NumMgr - 1) ? '0 : sel + 1'b1) : rr;
    for (int i = 0; i < int'(NumMgr); i++) begin
      sbr_ports_rsp_o[i] = mgr_port_rsp_i;
      sbr_ports_rsp_o[i].gnt = {3{push && sel == IW'(i)}};
      sbr_ports_rsp_o[i].rvalid = {3{has && rvalid_v && head == IW'(i)}};
    end
    fault_o = rst_i ? 2'b00 : {st_bad || (rvalid_v && !has), in_bad};
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rr_q <= '0;
      lidx_q <= '0;
      lock_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      for (int k = 0; k < int'(MaxTrans); k++) fifo_q[k] <= '0;
    end else begin
      rr_q <= {3{rr_d}};
      lidx_q <= {3{lidx_d}};
      lock_q <= {3{lock_d}};
      cnt_q <= {3{cnt_d}};
      wp_q <= {3{wp_d}};
      rp_q <= {3{rp_d}};
      if (push) fifo_q[wp] <= {3{sel}};
    end
endmodule
